// File: rtl/vec_gen_stream.sv
// vec_gen_stream: streams an N_BITS binary vector (sparse LFSR or unit e_idx), W bits per beat.
// Define VEC_GEN_WEIGHT_EN to add the 'weight' popcount output.
module vec_gen_stream #(
  parameter int unsigned N_BITS = 9800,
  parameter int unsigned W      = 8,
  parameter int unsigned IDX_W  = 14,
  parameter int unsigned DENS   = 8,
  parameter logic [15:0] SEED_C = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [W-1:0]     vec_data,
  output logic             vec_last,
  output logic             finish
`ifdef VEC_GEN_WEIGHT_EN
  ,
  output logic [$clog2(N_BITS+1)-1:0] weight
`endif
);

  localparam int unsigned BEATS     = (N_BITS + W - 1) / W;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {StIdle, StSeed, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_next, seed_val;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             mode_q;
  logic [W-1:0]     beat_bits;
  logic             xfer, at_last;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  assign seed_val = 16'(idx_q) ^ SEED_C;
  assign at_last  = (cnt_q == CNT_W'(BEATS - 1));
  assign xfer     = (state_q == StRun) && vec_ready;

  // W LFSR steps per beat; bit k sees the state after k+1 steps. Out-of-range bits stay 0.
  always_comb begin
    logic [31:0] pos;
    pos       = '0;
    lfsr_next = lfsr_q;
    beat_bits = '0;
    for (int k = 0; k < W; k++) begin
      lfsr_next = lfsr_step(lfsr_next);
      pos       = 32'(cnt_q) * W + 32'(k);
      if (pos < N_BITS) begin
        if (mode_q) beat_bits[k] = (pos == 32'(idx_q));
        else        beat_bits[k] = (32'(lfsr_next[7:0]) < DENS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    vec_valid = 1'b0;
    vec_data  = '0;
    vec_last  = 1'b0;
    finish    = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StSeed;
      end
      StSeed: state_d = StRun;
      StRun: begin
        vec_valid = 1'b1;
        vec_data  = beat_bits;
        vec_last  = at_last;
        if (vec_ready && at_last) state_d = StDone;
      end
      StDone: begin
        finish  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'h0001;
      cnt_q  <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        idx_q  <= idx;
        mode_q <= mode;
      end
      if (state_q == StSeed) begin
        lfsr_q <= (seed_val == 16'h0000) ? 16'h0001 : seed_val;
        cnt_q  <= '0;
      end
      if (xfer) begin
        lfsr_q <= lfsr_next;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef VEC_GEN_WEIGHT_EN
  localparam int unsigned WGT_W = $clog2(N_BITS + 1);
  logic [WGT_W-1:0] weight_q;

  always_ff @(posedge clk) begin
    if (rst)                    weight_q <= '0;
    else if (state_q == StSeed) weight_q <= '0;
    else if (xfer)              weight_q <= weight_q + WGT_W'($countones(beat_bits));
  end

  assign weight = weight_q;
`else
  // Beats are not inspected after generation when weight tracking is absent.
`endif

endmodule

// File: tb/tb_vec_gen_stream.sv
// Directed self-checking bench for vec_gen_stream (default parameters).
module tb_vec_gen_stream;
  localparam int N_BITS = 9800;
  localparam int W      = 8;
  localparam int IDX_W  = 14;
  localparam int BEATS  = 1225;

  logic             clk = 1'b0;
  logic             rst, start, mode, vec_ready;
  logic [IDX_W-1:0] idx;
  logic             busy, vec_valid, vec_last, finish;
  logic [W-1:0]     vec_data;
`ifdef VEC_GEN_WEIGHT_EN
  logic [$clog2(N_BITS+1)-1:0] weight;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_beat  [BEATS];
  logic [W-1:0] cap_data  [BEATS];
  logic         cap_last  [BEATS];
  logic [W-1:0] save_data [BEATS];
  int           exp_ones, first_bad;

  int   n_beats, lat, stall_err, early_fin, timeout, aborted;
  logic pre_busy, pre_fin, t1_valid, fin_done, busy_done, valid_done;
  bit   rnd_ready = 0;
  int   glitch_at = -1;
  int   abort_at  = -1;

  always #5 clk = ~clk;

  vec_gen_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .idx       (idx),
    .busy      (busy),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_last  (vec_last),
    .finish    (finish)
`ifdef VEC_GEN_WEIGHT_EN
    ,
    .weight    (weight)
`endif
  );

  // Bit-serial reference: one Galois step per vector position.
  task automatic build_model(input logic m, input int ix);
    logic [15:0] s;
    logic        b;
    int          p;
    s = 16'(ix) ^ 16'hACE1;
    if (s == 16'h0000) s = 16'h0001;
    exp_ones = 0;
    for (int bt = 0; bt < BEATS; bt++) begin
      exp_beat[bt] = '0;
      for (int k = 0; k < W; k++) begin
        p = bt * W + k;
        if (s[0]) s = (s >> 1) ^ 16'hB400;
        else      s = s >> 1;
        if (m) b = (p == ix);
        else   b = (s[7:0] < 8'd8);
        if (p >= N_BITS) b = 1'b0;
        exp_beat[bt][k] = b;
        if (b) exp_ones++;
      end
    end
  endtask

  function automatic int count_bad();
    int bad;
    bad = 0;
    first_bad = -1;
    for (int b = 0; b < BEATS; b++) begin
      if (b >= n_beats || cap_data[b] !== exp_beat[b] || cap_last[b] !== (b == BEATS - 1)) begin
        bad++;
        if (first_bad < 0) first_bad = b;
      end
    end
    return bad;
  endfunction

  // Starts one vector and captures its beats; returns at the negedge of the cycle after the last
  // transfer (or right after raising rst when abort_at is reached).
  task automatic drive_vector(input logic m, input logic [IDX_W-1:0] ix);
    int           cyc;
    bit           got_last, r, prev_stall;
    logic [W-1:0] held_d;
    logic         held_l;
    n_beats = 0; stall_err = 0; early_fin = 0; timeout = 0; aborted = 0; lat = -1;
    got_last = 0; prev_stall = 0; held_d = '0; held_l = 1'b0;
    @(negedge clk);
    pre_busy = busy;
    pre_fin  = finish;
    start = 1'b1; mode = m; idx = ix; vec_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; mode = ~m; idx = ~ix;
    t1_valid = vec_valid;
    cyc = 1;
    while (!got_last && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (finish) early_fin++;
      if (abort_at >= 0 && n_beats == abort_at) begin
        rst = 1'b1;
        vec_ready = 1'b0;
        abort_at = -1;
        aborted = 1;
        return;
      end
      r = rnd_ready ? bit'($urandom_range(0, 1)) : 1'b1;
      vec_ready = r;
      if (vec_valid) begin
        if (lat < 0) lat = cyc;
        if (prev_stall && (vec_data !== held_d || vec_last !== held_l)) stall_err++;
        if (glitch_at >= 0 && n_beats == glitch_at) begin
          start = 1'b1; mode = 1'b1; idx = 14'd77;
          glitch_at = -1;
        end
        if (r) begin
          cap_data[n_beats] = vec_data;
          cap_last[n_beats] = vec_last;
          if (vec_last) got_last = 1;
          n_beats++;
        end
        prev_stall = !r;
        held_d = vec_data;
        held_l = vec_last;
      end
    end
    if (!got_last) begin
      timeout = 1;
      return;
    end
    @(negedge clk);
    vec_ready  = 1'b0;
    fin_done   = finish;
    busy_done  = busy;
    valid_done = vec_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; idx = '0; vec_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (vec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", vec_valid); end
    vectors++; if (vec_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", vec_last); end
    vectors++; if (finish !== 1'b0) begin miscompares++; $display("FAIL reset_finish: got %b want 0", finish); end
    vectors++; if (vec_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", vec_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_unit_vector();
    int nz, bad_last;
    drive_vector(1'b1, 14'd100);
    vectors++; if (timeout !== 0) begin miscompares++; $display("FAIL unit_timeout: got %0d want 0", timeout); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL unit_latency: got %0d want 2", lat); end
    vectors++; if (t1_valid !== 1'b0) begin miscompares++; $display("FAIL unit_seed_valid: got %b want 0", t1_valid); end
    vectors++; if (n_beats !== BEATS) begin miscompares++; $display("FAIL unit_beats: got %0d want %0d", n_beats, BEATS); end
    vectors++; if (cap_data[12] !== 8'h10) begin miscompares++; $display("FAIL unit_beat12: got %h want 10", cap_data[12]); end
    nz = 0; bad_last = 0;
    for (int b = 0; b < BEATS; b++) begin
      if (b < n_beats && b != 12 && cap_data[b] !== 8'h00) nz++;
      if (b < BEATS - 1 && b < n_beats && cap_last[b] !== 1'b0) bad_last++;
    end
    vectors++; if (nz !== 0) begin miscompares++; $display("FAIL unit_zero_beats: got %0d nonzero want 0", nz); end
    vectors++; if (bad_last !== 0) begin miscompares++; $display("FAIL unit_early_last: got %0d want 0", bad_last); end
    vectors++; if (cap_last[BEATS-1] !== 1'b1) begin miscompares++; $display("FAIL unit_last: got %b want 1", cap_last[BEATS-1]); end
    vectors++; if (early_fin !== 0) begin miscompares++; $display("FAIL unit_early_finish: got %0d want 0", early_fin); end
    vectors++; if (fin_done !== 1'b1) begin miscompares++; $display("FAIL unit_finish: got %b want 1", fin_done); end
    vectors++; if (busy_done !== 1'b1 || valid_done !== 1'b0) begin
      miscompares++; $display("FAIL unit_done_state: got busy=%b valid=%b want busy=1 valid=0", busy_done, valid_done);
    end
  endtask

  task automatic test_out_of_range();
    int nz;
    drive_vector(1'b1, 14'd9800);
    vectors++; if (pre_fin !== 1'b0 || pre_busy !== 1'b0) begin
      miscompares++; $display("FAIL oor_idle: got finish=%b busy=%b want 0 0", pre_fin, pre_busy);
    end
    vectors++; if (n_beats !== BEATS) begin miscompares++; $display("FAIL oor_beats: got %0d want %0d", n_beats, BEATS); end
    nz = 0;
    for (int b = 0; b < BEATS; b++) if (b < n_beats && cap_data[b] !== 8'h00) nz++;
    vectors++; if (nz !== 0) begin miscompares++; $display("FAIL oor_zero: got %0d nonzero want 0", nz); end
    vectors++; if (fin_done !== 1'b1) begin miscompares++; $display("FAIL oor_finish: got %b want 1", fin_done); end
`ifdef VEC_GEN_WEIGHT_EN
    vectors++; if (weight !== '0) begin miscompares++; $display("FAIL oor_weight: got %0d want 0", weight); end
`endif
  endtask

  task automatic test_sparse_repeat();
    int bad, diff;
    build_model(1'b0, 980);
    drive_vector(1'b0, 14'd980);
    bad = count_bad();
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL sparse_model: got %0d bad beats (first %0d) want 0", bad, first_bad); end
`ifdef VEC_GEN_WEIGHT_EN
    vectors++; if (int'(weight) !== exp_ones) begin miscompares++; $display("FAIL sparse_weight: got %0d want %0d", weight, exp_ones); end
`endif
    for (int b = 0; b < BEATS; b++) save_data[b] = cap_data[b];
    drive_vector(1'b0, 14'd980);
    vectors++; if (pre_busy !== 1'b0 || pre_fin !== 1'b0) begin
      miscompares++; $display("FAIL b2b_idle: got busy=%b finish=%b want 0 0", pre_busy, pre_fin);
    end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL b2b_latency: got %0d want 2", lat); end
    diff = 0;
    for (int b = 0; b < BEATS; b++) if (b >= n_beats || cap_data[b] !== save_data[b]) diff++;
    vectors++; if (diff !== 0) begin miscompares++; $display("FAIL sparse_repeat: got %0d differing beats want 0", diff); end
  endtask

  task automatic test_stall();
    int bad;
    build_model(1'b0, 9799);
    rnd_ready = 1;
    drive_vector(1'b0, 14'd9799);
    rnd_ready = 0;
    bad = count_bad();
    vectors++; if (timeout !== 0) begin miscompares++; $display("FAIL stall_timeout: got %0d want 0", timeout); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_model: got %0d bad beats (first %0d) want 0", bad, first_bad); end
    vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_err); end
    vectors++; if (fin_done !== 1'b1) begin miscompares++; $display("FAIL stall_finish: got %b want 1", fin_done); end
  endtask

  task automatic test_start_ignored();
    int bad;
    build_model(1'b0, 5);
    glitch_at = 300;
    drive_vector(1'b0, 14'd5);
    bad = count_bad();
    vectors++; if (glitch_at !== -1) begin miscompares++; $display("FAIL glitch_applied: got %0d want -1", glitch_at); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL glitch_model: got %0d bad beats (first %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_abort();
    int fin_seen, bad;
    abort_at = 500;
    drive_vector(1'b0, 14'd980);
    vectors++; if (aborted !== 1) begin miscompares++; $display("FAIL abort_reached: got %0d want 1", aborted); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || vec_valid !== 1'b0 || finish !== 1'b0 || vec_data !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b valid=%b finish=%b data=%h want 0 0 0 00", busy, vec_valid, finish, vec_data);
    end
    rst = 1'b0;
    fin_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (finish !== 1'b0 || busy !== 1'b0) fin_seen++;
    end
    vectors++; if (fin_seen !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", fin_seen); end
    build_model(1'b0, 980);
    drive_vector(1'b0, 14'd980);
    bad = count_bad();
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL abort_rerun: got %0d bad beats (first %0d) want 0", bad, first_bad); end
    vectors++; if (fin_done !== 1'b1) begin miscompares++; $display("FAIL abort_rerun_finish: got %b want 1", fin_done); end
  endtask

  initial begin
    test_reset();
    test_unit_vector();
    test_out_of_range();
    test_sparse_repeat();
    test_stall();
    test_start_ignored();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
